// File: rtl/rc5_pkg.sv
// Shared definitions for the RC5 key-schedule block: magic constants,
// FSM state encoding, word rotate and schedule sizing helpers.
package rc5_pkg;

    localparam logic [15:0] P16 = 16'hB7E1;
    localparam logic [15:0] Q16 = 16'h9E37;
    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Left rotate of a width-bit word (16 or 32) held in the low bits of value.
    function automatic logic [31:0] rotl(input logic [31:0] value,
                                         input logic [4:0]  amount,
                                         input int          width);
        logic [63:0] dbl;
        if (width == 16) begin
            dbl = {32'd0, value[15:0], value[15:0]} << amount[3:0];
            return {16'd0, dbl[31:16]};
        end
        dbl = {value, value} << amount;
        return dbl[63:32];
    endfunction

    // Table length t = 2*(r+1), with r clamped to max_rounds.
    function automatic logic [6:0] calc_t(input logic [4:0] num_rounds,
                                          input int         max_rounds);
        int rr;
        rr = int'(num_rounds);
        if (rr > max_rounds) rr = max_rounds;
        return 7'(2 * (rr + 1));
    endfunction

    // Key length in words c = max(1, ceil(key_bytes*8/w)).
    function automatic int calc_c(input int key_bytes, input int w);
        int v;
        v = (key_bytes * 8 + w - 1) / w;
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/rc5_mix_step.sv
// One RC5 key-mixing iteration: produces the new A (written back to S[i])
// and the new B (written back to L[j]). Purely combinational.
module rc5_mix_step
    import rc5_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] i_s,
    input  logic [W-1:0] i_l,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_a,
    output logic [W-1:0] o_b
);

    logic [W-1:0] w_sum_a;
    logic [W-1:0] w_sum_b;
    logic [W-1:0] w_amt;

    // A' = rotl(S+A+B, 3); B' = rotl(L+A'+B, (A'+B) mod W)
    always_comb begin
        w_sum_a = i_s + i_a + i_b;
        o_a     = W'(rotl(32'(w_sum_a), 5'd3, W));
        w_amt   = o_a + i_b;
        w_sum_b = i_l + o_a + i_b;
        o_b     = W'(rotl(32'(w_sum_b), 5'(w_amt), W));
    end

endmodule

// File: rtl/rc5_key_expand.sv
// RC5 key expansion: builds the round-key table S[0..t-1] from the secret
// key, one INIT entry or one mix iteration per cycle, and serves it through
// a registered read port.
// Optional feature macro: RC5_KEY_ZEROIZE_EN (adds i_zeroize, which wipes
// S, L, A, B and the latched key in one cycle; rst then wipes them too).
//
// state | meaning
// IDLE  | waiting for start; table valid if a run has completed
// INIT  | writing S[n] = P + n*Q, one entry per cycle
// MIX   | 3*max(t,c) mixing iterations over S and L
// DONE  | last busy cycle; key_valid rises on exit
module rc5_key_expand
    import rc5_pkg::*;
#(
    parameter int W          = 16,
    parameter int KEY_BYTES  = 16,
    parameter int MAX_ROUNDS = 31
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
`ifdef RC5_KEY_ZEROIZE_EN
    input  logic                   i_zeroize,
`endif
    input  logic                   i_start,
    input  logic [4:0]             i_num_rounds,
    input  logic [8*KEY_BYTES-1:0] i_key,
    output logic                   o_busy,
    output logic                   o_key_valid,
    input  logic [5:0]             i_s_raddr,
    output logic [W-1:0]           o_s_rdata
);

    localparam int T_MAX = 2 * (MAX_ROUNDS + 1);
    localparam int C     = calc_c(KEY_BYTES, W);
    localparam int IW    = 6;
    localparam int JW    = (C > 1) ? $clog2(C) : 1;
    localparam logic [W-1:0] P_W = (W == 32) ? W'(P32) : W'(P16);
    localparam logic [W-1:0] Q_W = (W == 32) ? W'(Q32) : W'(Q16);

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_s [T_MAX];
    logic [W-1:0]   r_l [C];
    logic [IW-1:0]  r_i;
    logic [JW-1:0]  r_j;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_ival;
    logic [W-1:0]   r_rdata;
    logic [IW:0]    r_t;
    logic [8:0]     r_cnt;
    logic           r_busy;
    logic           r_key_valid;

    logic           w_zero;
    logic           w_accept;
    logic           w_cnt_zero;
    logic [IW:0]    w_t_new;
    logic [8:0]     w_mix_last;
    logic [IW-1:0]  w_i_next;
    logic [JW-1:0]  w_j_next;
    logic [W-1:0]   w_a_next;
    logic [W-1:0]   w_b_next;
    logic [C*W-1:0] w_key_pad;

`ifdef RC5_KEY_ZEROIZE_EN
    assign w_zero = i_zeroize;
`else
    assign w_zero = 1'b0;
`endif

    assign w_accept   = (r_state == IDLE) && i_start && !w_zero;
    assign w_cnt_zero = (r_cnt == 9'd0);
    assign w_t_new    = calc_t(i_num_rounds, MAX_ROUNDS);
    assign w_key_pad  = (C*W)'(i_key);
    assign w_i_next   = ({1'b0, r_i} == r_t - 1'b1) ? '0 : r_i + 1'b1;
    assign w_j_next   = (r_j == JW'(C - 1)) ? '0 : r_j + 1'b1;

    // Mix phase length minus one: 3*max(t,c) - 1, loaded into the down-counter.
    always_comb begin
        int tt;
        tt = int'(r_t);
        if (tt < C) tt = C;
        w_mix_last = 9'(3 * tt - 1);
    end

    rc5_mix_step #(.W(W)) u_mix_step (
        .i_s (r_s[r_i]),
        .i_l (r_l[r_j]),
        .i_a (r_a),
        .i_b (r_b),
        .o_a (w_a_next),
        .o_b (w_b_next)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; zeroize overrides everything.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = INIT;
            INIT:    if (w_cnt_zero) w_state_next = MIX;
            MIX:     if (w_cnt_zero) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (w_zero) w_state_next = IDLE;
    end

    // Control, indices, accumulators, phase timer and read-port register.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_zero) begin
            r_busy      <= 1'b0;
            r_key_valid <= 1'b0;
            r_rdata     <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_ival      <= '0;
            r_t         <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_busy      <= 1'b1;
                        r_key_valid <= 1'b0;
                        r_t         <= w_t_new;
                        r_cnt       <= 9'(w_t_new) - 9'd1;
                        r_i         <= '0;
                        r_j         <= '0;
                        r_a         <= '0;
                        r_b         <= '0;
                        r_ival      <= P_W;
                    end
                end
                INIT: begin
                    r_ival <= r_ival + Q_W;
                    if (w_cnt_zero) begin
                        r_i   <= '0;
                        r_j   <= '0;
                        r_a   <= '0;
                        r_b   <= '0;
                        r_cnt <= w_mix_last;
                    end else begin
                        r_i   <= r_i + 1'b1;
                        r_cnt <= r_cnt - 9'd1;
                    end
                end
                MIX: begin
                    r_a <= w_a_next;
                    r_b <= w_b_next;
                    r_i <= w_i_next;
                    r_j <= w_j_next;
                    if (!w_cnt_zero) r_cnt <= r_cnt - 9'd1;
                end
                DONE: begin
                    r_busy      <= 1'b0;
                    r_key_valid <= 1'b1;
                end
                default: ;
            endcase
            r_rdata <= (r_key_valid && ({1'b0, i_s_raddr} < r_t)) ? r_s[i_s_raddr] : '0;
        end
    end

    // Table and key-word storage: L loaded on accept, S filled in INIT, both updated in MIX.
    always_ff @(posedge i_clk) begin
`ifdef RC5_KEY_ZEROIZE_EN
        if (i_rst || i_zeroize) begin
            for (int n = 0; n < T_MAX; n++) r_s[n] <= '0;
            for (int k = 0; k < C; k++)     r_l[k] <= '0;
        end else
`endif
        if (!i_rst) begin
            if (w_accept) begin
                for (int k = 0; k < C; k++) r_l[k] <= w_key_pad[W*k +: W];
            end else if (r_state == INIT) begin
                r_s[r_i] <= r_ival;
            end else if (r_state == MIX) begin
                r_s[r_i] <= w_a_next;
                r_l[r_j] <= w_b_next;
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_key_valid = r_key_valid;
    assign o_s_rdata   = r_rdata;

endmodule
